// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants (FSM states, parity modes, DATA_BITS limits, parity helper)
package uart_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
  localparam int CNT_W = $clog2(DATA_BITS_MAX);
  function automatic logic parity_en(input logic [1:0] mode);
    return mode == PAR_EVEN || mode == PAR_ODD;
  endfunction
endpackage

// File: rtl/uart_tx_ext_if.sv
// uart_tx_ext_if: transmitter bus (word handshake, divisor load, frame options, serial line, status); master drives i_*, slave drives o_*
interface uart_tx_ext_if #(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16
);
  logic [DATA_BITS-1:0] i_data;
  logic                 i_valid;
  logic                 o_ready;
  logic [DIV_W-1:0]     i_div;
  logic                 i_div_we;
  logic [1:0]           i_parity;
  logic                 i_stop2;
  logic                 o_tx;
  logic                 o_busy;
  logic                 o_done;
  modport master (
    output i_data, i_valid, i_div, i_div_we, i_parity, i_stop2,
    input  o_ready, o_tx, o_busy, o_done
  );
  modport slave (
    input  i_data, i_valid, i_div, i_div_we, i_parity, i_stop2,
    output o_ready, o_tx, o_busy, o_done
  );
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter; i_en runs it (held at 0 otherwise), o_tick marks the last clock of each i_div+1 clock bit
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  always_comb begin
    o_tick = i_en && cnt_q == i_div;
    cnt_d  = (!i_en || o_tick) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
endmodule

// File: rtl/uart_tx_ext.sv
// uart_tx_ext: UART transmitter with runtime divisor, parity, 1/2 stop bits and one-entry holding buffer; i_clk/i_rst_n plus slave bus
module uart_tx_ext
  import uart_pkg::*;
#(
  parameter int          DATA_BITS   = 8,
  parameter int          DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 5207
) (
  input logic           i_clk,
  input logic           i_rst_n,
  uart_tx_ext_if.slave  bus
);
  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
    $error("uart_tx_ext: DATA_BITS out of range");
  end
  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, buf_q, buf_d, load_data;
  logic [CNT_W-1:0]     bit_q, bit_d;
  logic [DIV_W-1:0]     div_q, div_d, fdiv_q, fdiv_d;
  logic                 buf_full_q, buf_full_d;
  logic                 par_q, par_d, par_en_q, par_en_d, stop2_q, stop2_d;
  logic                 tx_q, tx_d;
  logic                 tick, accept, last_stop, load;
  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (state_q != ST_IDLE),
    .i_div   (fdiv_q),
    .o_tick  (tick)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      bit_q      <= '0;
      div_q      <= DIV_W'(DEFAULT_DIV);
      fdiv_q     <= '0;
      par_q      <= 1'b0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      bit_q      <= bit_d;
      div_q      <= div_d;
      fdiv_q     <= fdiv_d;
      par_q      <= par_d;
      par_en_q   <= par_en_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
    end
  // accept needs an empty buffer and drain needs a full one, so they never coincide
  always_comb begin
    accept     = bus.i_valid && !buf_full_q;
    last_stop  = state_q == ST_STOP && tick && bit_q == CNT_W'(stop2_q);
    load       = (state_q == ST_IDLE && accept) || (last_stop && buf_full_q);
    load_data  = state_q == ST_IDLE ? bus.i_data : buf_q;
    div_d      = bus.i_div_we ? bus.i_div : div_q;
    buf_d      = (accept && state_q != ST_IDLE) ? bus.i_data : buf_q;
    buf_full_d = (accept && state_q != ST_IDLE) || (buf_full_q && !last_stop);
    fdiv_d     = load ? div_q : fdiv_q;
    par_en_d   = load ? parity_en(bus.i_parity) : par_en_q;
    par_d      = load ? (^load_data) ^ (bus.i_parity == PAR_ODD) : par_q;
    stop2_d    = load ? bus.i_stop2 : stop2_q;
    shift_d    = load ? load_data : shift_q;
    state_d    = state_q;
    bit_d      = bit_q;
    unique case (state_q)
      ST_IDLE:   if (load) state_d = ST_START;
      ST_START:  if (tick) begin
        state_d = ST_DATA;
        bit_d   = '0;
      end
      ST_DATA:   if (tick) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 1'b1;
        if (bit_q == CNT_W'(DATA_BITS - 1)) begin
          state_d = par_en_q ? ST_PARITY : ST_STOP;
          bit_d   = '0;
        end
      end
      ST_PARITY: if (tick) state_d = ST_STOP;
      ST_STOP:   if (tick) begin
        bit_d = bit_q + 1'b1;
        if (last_stop) begin
          state_d = load ? ST_START : ST_IDLE;
          bit_d   = '0;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end
  // line level is registered from the next state so it changes exactly on bit boundaries
  always_comb begin
    tx_d        = state_d == ST_START  ? 1'b0 :
                  state_d == ST_DATA   ? shift_d[0] :
                  state_d == ST_PARITY ? par_q : 1'b1;
    bus.o_tx    = tx_q;
    bus.o_ready = !buf_full_q;
    bus.o_busy  = state_q != ST_IDLE || buf_full_q;
    bus.o_done  = last_stop;
  end
endmodule

// File: tb/tb_uart_tx_ext.sv
// tb_uart_tx_ext: directed self-checking bench for uart_tx_ext (8-bit and 9-bit instances)
module tb_uart_tx_ext;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  uart_tx_ext_if #(.DATA_BITS(8), .DIV_W(16)) bus8 ();
  uart_tx_ext_if #(.DATA_BITS(9), .DIV_W(16)) bus9 ();
  uart_tx_ext #(.DATA_BITS(8), .DIV_W(16)) dut8 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus8));
  uart_tx_ext #(.DATA_BITS(9), .DIV_W(16)) dut9 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus9));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input bit sel, input logic [8:0] data);
    if (sel) begin bus9.i_valid = 1'b1; bus9.i_data = data; end
    else begin bus8.i_valid = 1'b1; bus8.i_data = data[7:0]; end
    tick();
    bus8.i_valid = 1'b0;
    bus9.i_valid = 1'b0;
  endtask
  task automatic set_div(input bit sel, input logic [15:0] div);
    if (sel) begin bus9.i_div = div; bus9.i_div_we = 1'b1; end
    else begin bus8.i_div = div; bus8.i_div_we = 1'b1; end
    tick();
    bus8.i_div_we = 1'b0;
    bus9.i_div_we = 1'b0;
  endtask
  task automatic expect_seq(input string tag, input bit sel, input string seq, input int clks, input int fbits);
    for (int c = 0; c < seq.len() * clks; c++) begin
      logic tx, done, b;
      tx   = sel ? bus9.o_tx : bus8.o_tx;
      done = sel ? bus9.o_done : bus8.o_done;
      b    = seq[c / clks] == "1";
      check($sformatf("%s tx@%0d", tag, c), 32'(tx), 32'(b));
      check($sformatf("%s done@%0d", tag, c), 32'(done), 32'(((c + 1) % (fbits * clks)) == 0));
      tick();
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    bus8.i_data = '0; bus8.i_valid = 0; bus8.i_div = '0; bus8.i_div_we = 0; bus8.i_parity = 2'b00; bus8.i_stop2 = 0;
    bus9.i_data = '0; bus9.i_valid = 0; bus9.i_div = '0; bus9.i_div_we = 0; bus9.i_parity = 2'b00; bus9.i_stop2 = 0;
    repeat (3) tick();
    check("rst tx", 32'(bus8.o_tx), 32'(1));
    check("rst ready", 32'(bus8.o_ready), 32'(1));
    check("rst busy", 32'(bus8.o_busy), 32'(0));
    check("rst done", 32'(bus8.o_done), 32'(0));
    rst_n = 1'b1;
    tick();
    set_div(0, 16'd3);
    send(0, 9'h0A5);
    check("a5 busy", 32'(bus8.o_busy), 32'(1));
    expect_seq("a5", 0, "0101001011", 4, 10);
    check("a5 idle tx", 32'(bus8.o_tx), 32'(1));
    check("a5 idle busy", 32'(bus8.o_busy), 32'(0));
    bus8.i_parity = 2'b01;
    set_div(0, 16'd0);
    send(0, 9'h007);
    expect_seq("even07", 0, "01110000011", 1, 11);
    bus8.i_parity = 2'b10;
    send(0, 9'h007);
    expect_seq("odd07", 0, "01110000001", 1, 11);
    bus8.i_parity = 2'b00;
    bus8.i_stop2 = 1'b1;
    set_div(0, 16'd1);
    send(0, 9'h03C);
    check("b2b ready before", 32'(bus8.o_ready), 32'(1));
    fork
      expect_seq("b2b", 0, "0001111001101100001111", 2, 11);
      begin
        bus8.i_valid = 1'b1; bus8.i_data = 8'hC3;
        tick();
        bus8.i_valid = 1'b0;
        check("b2b ready low", 32'(bus8.o_ready), 32'(0));
        repeat (20) tick();
        check("b2b ready end1", 32'(bus8.o_ready), 32'(0));
        check("b2b busy end1", 32'(bus8.o_busy), 32'(1));
        tick();
        check("b2b ready rise", 32'(bus8.o_ready), 32'(1));
        repeat (21) tick();
        check("b2b busy last", 32'(bus8.o_busy), 32'(1));
      end
    join
    check("b2b busy after", 32'(bus8.o_busy), 32'(0));
    send(0, 9'h055);
    fork
      expect_seq("full", 0, "01010101011011110000111111", 2, 11);
      begin
        bus8.i_valid = 1'b1; bus8.i_data = 8'h0F;
        tick();
        bus8.i_valid = 1'b0;
        repeat (2) tick();
        bus8.i_valid = 1'b1; bus8.i_data = 8'hFF;
        check("full ready", 32'(bus8.o_ready), 32'(0));
        repeat (8) tick();
        bus8.i_valid = 1'b0;
      end
    join
    check("full busy after", 32'(bus8.o_busy), 32'(0));
    bus9.i_parity = 2'b10;
    bus9.i_stop2 = 1'b1;
    set_div(1, 16'd2);
    send(1, 9'h1FF);
    expect_seq("nine", 1, "0111111111011", 3, 13);
    check("nine idle", 32'(bus9.o_busy), 32'(0));
    bus8.i_stop2 = 1'b0;
    set_div(0, 16'd3);
    send(0, 9'h0A5);
    repeat (17) tick();
    check("pre rst tx", 32'(bus8.o_tx), 32'(0));
    rst_n = 1'b0;
    #1;
    check("mid rst tx", 32'(bus8.o_tx), 32'(1));
    check("mid rst ready", 32'(bus8.o_ready), 32'(1));
    check("mid rst busy", 32'(bus8.o_busy), 32'(0));
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("post rst tx@%0d", i), 32'(bus8.o_tx), 32'(1));
      check($sformatf("post rst busy@%0d", i), 32'(bus8.o_busy), 32'(0));
      tick();
    end
    rst_n = 1'b0;
    tick();
    bus8.i_valid = 1'b1; bus8.i_data = 8'h01;
    rst_n = 1'b1;
    tick();
    bus8.i_valid = 1'b0;
    check("first accept tx", 32'(bus8.o_tx), 32'(0));
    check("first accept busy", 32'(bus8.o_busy), 32'(1));
    rst_n = 1'b0;
    #1;
    check("abort tx", 32'(bus8.o_tx), 32'(1));
    tick();
    rst_n = 1'b1;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
